shoelace_chain_checker: RTL and testbench



---
 rtl/shoelace_pkg.sv | 38 +++
 rtl/shoelace_chain_checker_toggle_sampler.sv | 27 ++
 rtl/shoelace_chain_checker.sv | 169 ++++++++++++++++
 tb/tb_shoelace_chain_checker.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shoelace_pkg.sv
// Shared types and helpers for the inverter-chain ripple checker.
package shoelace_pkg;

   // Widest tap vector the helpers below support.
   localparam int unsigned MAX_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      ERROR = 2'd2
   } state_t;

   // err_tap code that names the stimulus rather than a tap: one past the last tap.
   function automatic int unsigned err_stim(input int unsigned n_taps);
      return n_taps;
   endfunction

   // One-hot vector with bit idx set.
   function automatic logic [MAX_W-1:0] onehot(input int unsigned idx);
      return MAX_W'(1) << idx;
   endfunction

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic int unsigned lowest_set(input logic [MAX_W-1:0] v);
      int unsigned res;
      logic        found;
      res   = 0;
      found = 1'b0;
      for (int unsigned i = 0; i < MAX_W; i++) begin
         if (v[i] && !found) begin
            res   = i;
            found = 1'b1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/shoelace_chain_checker_toggle_sampler.sv
// Registers an input vector once, keeps the previous sample, flags toggles.
module toggle_sampler #(
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] ev_c
);

   logic [W-1:0] s_q;
   logic [W-1:0] s_p;

   // Reset preloads both stages from the live input so no edge is seen on release.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q <= din;
         s_p <= din;
      end else begin
         s_q <= din;
         s_p <= s_q;
      end
   end

   assign ev_c = s_q ^ s_p;

endmodule

// File: rtl/shoelace_chain_checker.sv
// Checks that each stimulus toggle ripples through the returned taps in order.
module shoelace_chain_checker
   import shoelace_pkg::*;
#(
   parameter int unsigned N_TAPS  = 5,
   parameter int unsigned TIMEOUT = 8,
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned LAT_W   = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        stim,
   input  logic [N_TAPS-1:0]           taps,
   input  logic                        clear_err,
   output logic                        busy,
   output logic                        done_pulse,
   output logic [CNT_W-1:0]            wave_count,
   output logic [LAT_W-1:0]            last_latency,
   output logic                        err_order,
   output logic                        err_timeout,
   output logic [$clog2(N_TAPS+1)-1:0] err_tap
);

   localparam int unsigned SW    = N_TAPS + 1;
   localparam int unsigned ERR_W = $clog2(N_TAPS + 1);
   localparam int unsigned EXP_W = $clog2(N_TAPS);
   localparam int unsigned HOP_W = $clog2(TIMEOUT + 1);

   localparam logic [ERR_W-1:0] ERR_STIM   = ERR_W'(err_stim(N_TAPS));
   localparam logic [EXP_W-1:0] LAST_EXP   = EXP_W'(N_TAPS - 1);
   localparam logic [HOP_W-1:0] HOP_LIMIT  = HOP_W'(TIMEOUT);

   logic [SW-1:0]     ev_c;
   logic              ev_stim_c;
   logic [N_TAPS-1:0] ev_taps_c;

   state_t            state_q, state_d;
   logic [EXP_W-1:0]  exp_q, exp_d;
   logic [HOP_W-1:0]  hop_q, hop_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic              busy_d;
   logic              done_d;
   logic [CNT_W-1:0]  wave_d;
   logic [LAT_W-1:0]  last_lat_d;
   logic              eo_d;
   logic              et_d;
   logic [ERR_W-1:0]  etap_d;

   logic [LAT_W-1:0]  lat_inc_c;
   logic [HOP_W-1:0]  hop_inc_c;
   logic [N_TAPS-1:0] exp_oh_c;
   logic [N_TAPS-1:0] wrong_c;

   toggle_sampler #(.W(SW)) u_sampler (
      .clk  (clk),
      .rst  (rst),
      .din  ({stim, taps}),
      .ev_c (ev_c)
   );

   assign ev_stim_c = ev_c[N_TAPS];
   assign ev_taps_c = ev_c[N_TAPS-1:0];

   // Register file: FSM state, wave tracking and every output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         exp_q        <= '0;
         hop_q        <= '0;
         lat_q        <= '0;
         busy         <= 1'b0;
         done_pulse   <= 1'b0;
         wave_count   <= '0;
         last_latency <= '0;
         err_order    <= 1'b0;
         err_timeout  <= 1'b0;
         err_tap      <= '0;
      end else begin
         state_q      <= state_d;
         exp_q        <= exp_d;
         hop_q        <= hop_d;
         lat_q        <= lat_d;
         busy         <= busy_d;
         done_pulse   <= done_d;
         wave_count   <= wave_d;
         last_latency <= last_lat_d;
         err_order    <= eo_d;
         err_timeout  <= et_d;
         err_tap      <= etap_d;
      end
   end

   // Next-state and next-output logic; checks in WAIT are prioritised stim, order, match, timeout.
   always_comb begin
      state_d    = state_q;
      exp_d      = exp_q;
      hop_d      = hop_q;
      lat_d      = lat_q;
      done_d     = 1'b0;
      wave_d     = wave_count;
      last_lat_d = last_latency;
      eo_d       = err_order;
      et_d       = err_timeout;
      etap_d     = err_tap;

      lat_inc_c  = (lat_q == '1) ? lat_q : lat_q + LAT_W'(1);
      hop_inc_c  = hop_q + HOP_W'(1);
      exp_oh_c   = N_TAPS'(onehot(32'(exp_q)));
      wrong_c    = ev_taps_c & ~exp_oh_c;

      case (state_q)
         IDLE: begin
            if (|ev_taps_c) begin
               state_d = ERROR;
               eo_d    = 1'b1;
               etap_d  = ERR_W'(lowest_set(MAX_W'(ev_taps_c)));
            end else if (ev_stim_c) begin
               state_d = WAIT;
               exp_d   = '0;
               hop_d   = '0;
               lat_d   = '0;
            end
         end
         WAIT: begin
            lat_d = lat_inc_c;
            if (ev_stim_c) begin
               state_d = ERROR;
               eo_d    = 1'b1;
               etap_d  = ERR_STIM;
            end else if ((|ev_taps_c) && (ev_taps_c != exp_oh_c)) begin
               state_d = ERROR;
               eo_d    = 1'b1;
               etap_d  = ERR_W'(lowest_set(MAX_W'(wrong_c)));
            end else if (ev_taps_c == exp_oh_c) begin
               if (exp_q == LAST_EXP) begin
                  state_d    = IDLE;
                  done_d     = 1'b1;
                  wave_d     = wave_count + CNT_W'(1);
                  last_lat_d = lat_inc_c;
               end else begin
                  exp_d = exp_q + EXP_W'(1);
                  hop_d = '0;
               end
            end else begin
               hop_d = hop_inc_c;
               if (hop_inc_c == HOP_LIMIT) begin
                  state_d = ERROR;
                  et_d    = 1'b1;
                  etap_d  = ERR_W'(exp_q);
               end
            end
         end
         ERROR: begin
            if (clear_err) begin
               state_d = IDLE;
               eo_d    = 1'b0;
               et_d    = 1'b0;
               etap_d  = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == WAIT);
   end

endmodule

// File: tb/tb_shoelace_chain_checker.sv
// Directed bench for shoelace_chain_checker with a done-pulse scoreboard.
module tb_shoelace_chain_checker;

   localparam int unsigned N_TAPS  = 5;
   localparam int unsigned TIMEOUT = 8;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned LAT_W   = 8;

   logic                        clk = 1'b0;
   logic                        rst;
   logic                        stim;
   logic [N_TAPS-1:0]           taps;
   logic                        clear_err;
   logic                        busy;
   logic                        done_pulse;
   logic [CNT_W-1:0]            wave_count;
   logic [LAT_W-1:0]            last_latency;
   logic                        err_order;
   logic                        err_timeout;
   logic [$clog2(N_TAPS+1)-1:0] err_tap;

   typedef struct {
      int unsigned wc;
      int unsigned lat;
   } exp_t;

   exp_t        sb[$];
   int unsigned exp_wc;
   int          checks = 0;
   int          errors = 0;

   shoelace_chain_checker #(
      .N_TAPS (N_TAPS),
      .TIMEOUT(TIMEOUT),
      .CNT_W  (CNT_W),
      .LAT_W  (LAT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stim        (stim),
      .taps        (taps),
      .clear_err   (clear_err),
      .busy        (busy),
      .done_pulse  (done_pulse),
      .wave_count  (wave_count),
      .last_latency(last_latency),
      .err_order   (err_order),
      .err_timeout (err_timeout),
      .err_tap     (err_tap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tog_tap(input int k);
      taps[k] = ~taps[k];
   endtask

   // Clean wave: stim then taps 0..4 one cycle apart; done expected with latency 5.
   task automatic clean_wave();
      exp_t e;
      exp_wc = (exp_wc + 1) & 32'hFFFF;
      e.wc   = exp_wc;
      e.lat  = 5;
      sb.push_back(e);
      stim = ~stim;
      step();
      for (int k = 0; k < int'(N_TAPS); k++) begin
         tog_tap(k);
         step();
      end
      step();
   endtask

   task automatic do_clear();
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
   endtask

   // Scoreboard: every done pulse must match the oldest expected wave.
   always @(negedge clk) begin
      if (rst === 1'b0 && done_pulse === 1'b1) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_done observed=1 expected=0 wave_count=%0d", wave_count);
         end
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_wave_count", 32'(wave_count), e.wc);
            chk("sb_last_latency", 32'(last_latency), e.lat);
         end
      end
   end

   initial begin
      rst       = 1'b1;
      stim      = 1'b1;
      taps      = 5'b10101;
      clear_err = 1'b0;
      exp_wc    = 0;
      step();
      step();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done_pulse), 0);
      chk("rst_wave_count", 32'(wave_count), 0);
      chk("rst_last_latency", 32'(last_latency), 0);
      chk("rst_err_order", 32'(err_order), 0);
      chk("rst_err_timeout", 32'(err_timeout), 0);
      chk("rst_err_tap", 32'(err_tap), 0);
      rst = 1'b0;
      step();
      step();
      step();
      chk("post_rst_no_false_edge", 32'(err_order), 0);
      chk("post_rst_idle", 32'(busy), 0);

      // Clean wave, with busy checked in flight.
      stim = ~stim;
      exp_wc = exp_wc + 1;
      begin
         exp_t e;
         e.wc = exp_wc; e.lat = 5;
         sb.push_back(e);
      end
      step();
      chk("idle_before_stim_seen", 32'(busy), 0);
      tog_tap(0); step();
      chk("busy_in_wave", 32'(busy), 1);
      for (int k = 1; k < int'(N_TAPS); k++) begin
         tog_tap(k); step();
      end
      chk("busy_before_last", 32'(busy), 1);
      step();
      chk("clean_done", 32'(done_pulse), 1);
      chk("clean_wave_count", 32'(wave_count), 1);
      chk("clean_latency", 32'(last_latency), 5);
      chk("clean_err_order", 32'(err_order), 0);
      chk("clean_err_timeout", 32'(err_timeout), 0);
      step();
      chk("clean_done_one_cycle", 32'(done_pulse), 0);
      chk("clean_busy_low", 32'(busy), 0);

      // Swapped order: tap2 before tap1.
      stim = ~stim; step();
      tog_tap(0); step();
      tog_tap(2); step();
      step();
      chk("swap_err_order", 32'(err_order), 1);
      chk("swap_err_tap", 32'(err_tap), 2);
      chk("swap_busy", 32'(busy), 0);
      chk("swap_wave_count", 32'(wave_count), 1);
      tog_tap(1); step(); step();
      chk("swap_error_held", 32'(err_order), 1);
      do_clear();
      chk("swap_cleared_order", 32'(err_order), 0);
      chk("swap_cleared_tap", 32'(err_tap), 0);
      step();
      chk("swap_no_stale_edge", 32'(err_order), 0);
      clean_wave();
      chk("swap_recover_count", 32'(wave_count), 2);

      // Timeout: tap3 never toggles.
      stim = ~stim; step();
      tog_tap(0); step();
      tog_tap(1); step();
      tog_tap(2); step();
      step();
      for (int i = 0; i < int'(TIMEOUT) - 1; i++) step();
      chk("timeout_not_yet", 32'(err_timeout), 0);
      chk("timeout_busy_still", 32'(busy), 1);
      step();
      chk("timeout_err", 32'(err_timeout), 1);
      chk("timeout_err_tap", 32'(err_tap), 3);
      chk("timeout_err_order", 32'(err_order), 0);
      chk("timeout_busy", 32'(busy), 0);
      do_clear();
      chk("timeout_cleared", 32'(err_timeout), 0);

      // Overrun: new stim toggle together with tap2 at exp=2.
      stim = ~stim; step();
      tog_tap(0); step();
      tog_tap(1); step();
      stim = ~stim; tog_tap(2); step();
      step();
      chk("overrun_err_order", 32'(err_order), 1);
      chk("overrun_err_tap", 32'(err_tap), 5);
      chk("overrun_err_timeout", 32'(err_timeout), 0);
      chk("overrun_wave_count", 32'(wave_count), 2);
      do_clear();

      // Spurious tap in IDLE.
      tog_tap(1); step(); step();
      chk("spurious_err_order", 32'(err_order), 1);
      chk("spurious_err_tap", 32'(err_tap), 1);
      do_clear();

      // Two taps at once while expecting tap0.
      stim = ~stim; step();
      tog_tap(0); tog_tap(1); step();
      step();
      chk("simul_err_order", 32'(err_order), 1);
      chk("simul_err_tap", 32'(err_tap), 1);
      do_clear();

      // Reset mid-wave at exp=3.
      stim = ~stim; step();
      tog_tap(0); step();
      tog_tap(1); step();
      tog_tap(2); step();
      step();
      rst = 1'b1;
      step();
      exp_wc = 0;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_done", 32'(done_pulse), 0);
      chk("midrst_wave_count", 32'(wave_count), 0);
      chk("midrst_last_latency", 32'(last_latency), 0);
      chk("midrst_err_order", 32'(err_order), 0);
      rst = 1'b0;
      step();
      tog_tap(3); step(); step();
      chk("midrst_leftover_order", 32'(err_order), 1);
      chk("midrst_leftover_tap", 32'(err_tap), 3);
      do_clear();
      for (int w = 0; w < 3; w++) clean_wave();
      chk("midrst_three_waves", 32'(wave_count), 3);
      chk("midrst_final_latency", 32'(last_latency), 5);

      step();
      chk("sb_drained", 32'(sb.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
